// File: rtl/ex_mem_sequencer_pkg.sv
// Shared constants, stall-bus encoding and bus-width helpers for the EX-stage memory sequencer.
package ex_mem_sequencer_pkg;

    localparam int   STALLBUS_WD   = 6;
    localparam int   EX_STALL_BIT  = 3;
    localparam int   MEM_STALL_BIT = 4;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;

    localparam int DEF_NLANE   = 2;
    localparam int DEF_LANE_WD = 280;
    localparam int DEF_RES_WD  = 70;

    typedef enum logic [1:0] {
        BR_HOLD,
        BR_LOAD,
        BR_BUBBLE,
        BR_CLEAR
    } bundle_act_e;

    function automatic int id_bus_wd(input int nlane, input int lane_wd);
        return 1 + nlane * lane_wd + nlane;
    endfunction

    function automatic int mem_bus_wd(input int nlane, input int res_wd);
        return 1 + nlane + nlane * res_wd;
    endfunction

endpackage

// File: rtl/ex_mem_sequencer_arb.sv
// Lowest-index-first picker over the lanes still waiting for the shared data SRAM port.
module ex_mem_arb #(
    parameter int NLANE = 2
) (
    input  logic             en,
    input  logic [NLANE-1:0] req,
    output logic [NLANE-1:0] grant,
    output logic             more
);

    always_comb begin
        grant = '0;
        if (en) begin
            grant = req & (~req + NLANE'(1));
        end
        more = |(req & ~grant);
    end

endmodule

// File: rtl/ex_mem_sequencer.sv
// Holds an issued bundle in EX and serialises its lanes' memory requests onto one data SRAM port.
module ex_mem_sequencer
    import ex_mem_sequencer_pkg::*;
#(
    parameter  int NLANE   = DEF_NLANE,
    parameter  int LANE_WD = DEF_LANE_WD,
    parameter  int RES_WD  = DEF_RES_WD,
    localparam int ID_WD   = id_bus_wd(NLANE, LANE_WD),
    localparam int MEM_WD  = mem_bus_wd(NLANE, RES_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [STALLBUS_WD-1:0]  stall,
    output logic                    stallreq_for_ex,
    input  logic [ID_WD-1:0]        id_to_ex_bus,
    output logic [ID_WD-1:0]        id_bus_r,
    input  logic [NLANE*RES_WD-1:0] lane_res,
    input  logic [NLANE-1:0]        lane_mem_en,
    input  logic [NLANE*4-1:0]      lane_mem_wen,
    input  logic [NLANE*32-1:0]     lane_mem_addr,
    input  logic [NLANE*32-1:0]     lane_mem_wdata,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic [MEM_WD-1:0]       ex_to_mem_bus
);

    logic                    ex_stop;
    logic                    mem_stop;
    logic                    arb_en;
    logic                    more;
    logic                    fresh;
    logic                    bundle_switch;
    logic [NLANE-1:0]        valid;
    logic [NLANE-1:0]        served;
    logic [NLANE-1:0]        pending;
    logic [NLANE-1:0]        grant;
    logic [NLANE-1:0]        valid_out;
    logic [NLANE-1:0]        vo_bus;
    logic [NLANE*RES_WD-1:0] res_bus;
    bundle_act_e             bundle_act;
    logic                    unused_stall;

    assign ex_stop       = (stall[EX_STALL_BIT] == STOP);
    assign mem_stop      = (stall[MEM_STALL_BIT] == STOP);
    assign unused_stall  = ^{stall[STALLBUS_WD-1:MEM_STALL_BIT+1], stall[EX_STALL_BIT-1:0]};
    assign valid         = id_bus_r[NLANE-1:0];
    assign bundle_switch = id_bus_r[ID_WD-1];
    assign pending       = valid & lane_mem_en & ~served;
    assign arb_en        = !mem_stop && !flush;

    ex_mem_arb #(
        .NLANE (NLANE)
    ) u_arb (
        .en    (arb_en),
        .req   (pending),
        .grant (grant),
        .more  (more)
    );

    assign stallreq_for_ex = more & ~flush;

    // A bundle that still owes SRAM accesses stays in place even while the EX stop bit asks for a bubble.
    always_comb begin
        if (flush) begin
            bundle_act = BR_CLEAR;
        end else if (stallreq_for_ex) begin
            bundle_act = BR_HOLD;
        end else if (ex_stop && !mem_stop) begin
            bundle_act = BR_BUBBLE;
        end else if (!ex_stop) begin
            bundle_act = BR_LOAD;
        end else begin
            bundle_act = BR_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_bus_r <= '0;
            served   <= '0;
            fresh    <= 1'b0;
        end else begin
            case (bundle_act)
                BR_LOAD: begin
                    id_bus_r <= id_to_ex_bus;
                    served   <= '0;
                    fresh    <= 1'b1;
                end
                BR_HOLD: begin
                    served <= served | grant;
                    if (!mem_stop) begin
                        fresh <= 1'b0;
                    end
                end
                default: begin
                    id_bus_r <= '0;
                    served   <= '0;
                    fresh    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (grant[i]) begin
                data_sram_en    = 1'b1;
                data_sram_wen   = lane_mem_wen[i*4 +: 4];
                data_sram_addr  = lane_mem_addr[i*32 +: 32];
                data_sram_wdata = lane_mem_wdata[i*32 +: 32];
            end
        end
    end

    // ALU lanes leave on the first unstalled cycle; memory lanes leave on the cycle they are granted.
    always_comb begin
        valid_out = '0;
        vo_bus    = '0;
        res_bus   = '0;
        for (int i = 0; i < NLANE; i++) begin
            valid_out[i] = valid[i] & !mem_stop & ((~lane_mem_en[i] & fresh) | grant[i]);
        end
        for (int j = 0; j < NLANE; j++) begin
            if (bundle_switch) begin
                vo_bus[j]                   = valid_out[NLANE-1-j];
                res_bus[j*RES_WD +: RES_WD] = lane_res[(NLANE-1-j)*RES_WD +: RES_WD];
            end else begin
                vo_bus[j]                   = valid_out[j];
                res_bus[j*RES_WD +: RES_WD] = lane_res[j*RES_WD +: RES_WD];
            end
        end
    end

    assign ex_to_mem_bus = {bundle_switch, vo_bus, res_bus};

endmodule

// File: tb/tb_ex_mem_sequencer.sv
// Bench for ex_mem_sequencer: a 2-lane and a 4-lane instance checked against a lane-queue reference model.
`timescale 1ns/1ps
module tb_ex_mem_sequencer;
    import ex_mem_sequencer_pkg::*;

    localparam int RW   = 70;
    localparam int LW_A = 280;
    localparam int LW_B = 16;
    localparam int ID_A = 1 + 2*LW_A + 2;
    localparam int ID_B = 1 + 4*LW_B + 4;
    localparam int MB_A = 1 + 2 + 2*RW;
    localparam int MB_B = 1 + 4 + 4*RW;
    localparam int CW   = 600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                   flush_a, mem_stop_a, stallreq_a;
    logic [STALLBUS_WD-1:0] stall_a;
    logic [ID_A-1:0]        id_a, idr_a;
    logic [2*RW-1:0]        res_a;
    logic [1:0]             en_a;
    logic [7:0]             wen_a;
    logic [63:0]            addr_a, wdata_a;
    logic                   sen_a;
    logic [3:0]             swen_a;
    logic [31:0]            saddr_a, swdata_a;
    logic [MB_A-1:0]        mb_a;

    logic                   flush_b, mem_stop_b, stallreq_b;
    logic [STALLBUS_WD-1:0] stall_b;
    logic [ID_B-1:0]        id_b, idr_b;
    logic [4*RW-1:0]        res_b;
    logic [3:0]             en_b;
    logic [15:0]            wen_b;
    logic [127:0]           addr_b, wdata_b;
    logic                   sen_b;
    logic [3:0]             swen_b;
    logic [31:0]            saddr_b, swdata_b;
    logic [MB_B-1:0]        mb_b;

    // Minimal stall controller: a MEM stop also stops EX, and the sequencer's own request stops EX.
    assign stall_a = {1'b0, mem_stop_a, stallreq_a | mem_stop_a, 3'b000};
    assign stall_b = {1'b0, mem_stop_b, stallreq_b | mem_stop_b, 3'b000};

    ex_mem_sequencer #(.NLANE(2), .LANE_WD(LW_A), .RES_WD(RW)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .stall(stall_a), .stallreq_for_ex(stallreq_a),
        .id_to_ex_bus(id_a), .id_bus_r(idr_a), .lane_res(res_a), .lane_mem_en(en_a),
        .lane_mem_wen(wen_a), .lane_mem_addr(addr_a), .lane_mem_wdata(wdata_a),
        .data_sram_en(sen_a), .data_sram_wen(swen_a), .data_sram_addr(saddr_a),
        .data_sram_wdata(swdata_a), .ex_to_mem_bus(mb_a)
    );

    ex_mem_sequencer #(.NLANE(4), .LANE_WD(LW_B), .RES_WD(RW)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .stall(stall_b), .stallreq_for_ex(stallreq_b),
        .id_to_ex_bus(id_b), .id_bus_r(idr_b), .lane_res(res_b), .lane_mem_en(en_b),
        .lane_mem_wen(wen_b), .lane_mem_addr(addr_b), .lane_mem_wdata(wdata_b),
        .data_sram_en(sen_b), .data_sram_wen(swen_b), .data_sram_addr(saddr_b),
        .data_sram_wdata(swdata_b), .ex_to_mem_bus(mb_b)
    );

    // Reference model: the bundle in EX plus a queue of memory lanes still to be issued.
    int            nl;
    bit            m_sw;
    bit            m_v[4];
    bit            m_me[4];
    logic [3:0]    m_wen[4];
    logic [31:0]   m_addr[4];
    logic [31:0]   m_wdata[4];
    logic [RW-1:0] m_res[4];
    int            q[$];
    bit            first;
    logic [CW-1:0] exp_id;
    int            n_checks = 0;
    int            n_err    = 0;
    int            req_high = 0;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        m_sw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 1'b0; m_me[i] = 1'b0; m_wen[i] = '0;
            m_addr[i] = '0; m_wdata[i] = '0; m_res[i] = '0;
        end
    endtask

    task automatic drive_lanes(input int sel);
        for (int i = 0; i < 4; i++) begin
            if (sel == 0 && i < 2) begin
                en_a[i] = m_me[i];
                wen_a[i*4 +: 4] = m_wen[i];
                addr_a[i*32 +: 32] = m_addr[i];
                wdata_a[i*32 +: 32] = m_wdata[i];
                res_a[i*RW +: RW] = m_res[i];
            end else if (sel == 1) begin
                en_b[i] = m_me[i];
                wen_b[i*4 +: 4] = m_wen[i];
                addr_b[i*32 +: 32] = m_addr[i];
                wdata_b[i*32 +: 32] = m_wdata[i];
                res_b[i*RW +: RW] = m_res[i];
            end
        end
    endtask

    task automatic load_bundle(input int sel);
        logic [ID_A-1:0] ba;
        logic [ID_B-1:0] bb;
        drive_lanes(sel);
        if (sel == 0) begin
            ba = '0;
            for (int b = 2; b < ID_A-1; b++) ba[b] = ($urandom() % 2) == 1;
            ba[ID_A-1] = m_sw;
            for (int i = 0; i < 2; i++) ba[i] = m_v[i];
            id_a = ba;
            exp_id = CW'(ba);
        end else begin
            bb = '0;
            for (int b = 4; b < ID_B-1; b++) bb[b] = ($urandom() % 2) == 1;
            bb[ID_B-1] = m_sw;
            for (int i = 0; i < 4; i++) bb[i] = m_v[i];
            id_b = bb;
            exp_id = CW'(bb);
        end
        @(posedge clk); #1;
        id_a = '0;
        id_b = '0;
        check("id_load", (sel == 0) ? CW'(idr_a) : CW'(idr_b), exp_id);
        q.delete();
        for (int i = 0; i < nl; i++) if (m_v[i] && m_me[i]) q.push_back(i);
        first = 1'b1;
    endtask

    task automatic check_output(input int sel, input bit ms, input bit fl);
        int              gnt, rem, src;
        logic [3:0]      vo_l, exp_vo, got_vo, exp_wen, got_wen;
        logic [4*RW-1:0] exp_res, got_res;
        logic            exp_en, got_en, got_sw, got_req;
        logic [31:0]     exp_addr, exp_wdata, got_addr, got_wdata;
        gnt = (!fl && !ms && q.size() > 0) ? q[0] : -1;
        rem = fl ? 0 : q.size() - ((gnt >= 0) ? 1 : 0);
        vo_l = '0;
        if (!ms) begin
            for (int i = 0; i < nl; i++) if (first && m_v[i] && !m_me[i]) vo_l[i] = 1'b1;
            if (gnt >= 0) vo_l[gnt] = 1'b1;
        end
        exp_en    = (gnt >= 0);
        exp_wen   = (gnt >= 0) ? m_wen[gnt]   : 4'h0;
        exp_addr  = (gnt >= 0) ? m_addr[gnt]  : 32'h0;
        exp_wdata = (gnt >= 0) ? m_wdata[gnt] : 32'h0;
        exp_vo  = '0;
        exp_res = '0;
        for (int j = 0; j < nl; j++) begin
            src = m_sw ? nl - 1 - j : j;
            exp_vo[j] = vo_l[src];
            exp_res[j*RW +: RW] = m_res[src];
        end
        if (sel == 0) begin
            got_en = sen_a; got_wen = swen_a; got_addr = saddr_a; got_wdata = swdata_a;
            got_req = stallreq_a;
            got_sw  = mb_a[MB_A-1];
            got_vo  = 4'(mb_a[MB_A-2 -: 2]);
            got_res = (4*RW)'(mb_a[2*RW-1:0]);
        end else begin
            got_en = sen_b; got_wen = swen_b; got_addr = saddr_b; got_wdata = swdata_b;
            got_req = stallreq_b;
            got_sw  = mb_b[MB_B-1];
            got_vo  = mb_b[MB_B-2 -: 4];
            got_res = mb_b[4*RW-1:0];
        end
        if (got_req === 1'b1) req_high++;
        check("sram_en",    CW'(got_en),    CW'(exp_en));
        check("sram_wen",   CW'(got_wen),   CW'(exp_wen));
        check("sram_addr",  CW'(got_addr),  CW'(exp_addr));
        check("sram_wdata", CW'(got_wdata), CW'(exp_wdata));
        check("stallreq",   CW'(got_req),   CW'(rem > 0));
        check("bus_switch", CW'(got_sw),    CW'(m_sw));
        check("valid_out",  CW'(got_vo),    CW'(exp_vo));
        check("results",    CW'(got_res),   CW'(exp_res));
    endtask

    task automatic step(input int sel, input bit ms, input bit fl);
        if (sel == 0) begin mem_stop_a = ms; flush_a = fl; end
        else          begin mem_stop_b = ms; flush_b = fl; end
        #1;
        check_output(sel, ms, fl);
        @(posedge clk); #1;
        if (fl) q.delete();
        else if (!ms && q.size() > 0) void'(q.pop_front());
        if (fl || !ms) first = 1'b0;
        if (fl || (!ms && q.size() == 0)) begin
            m_sw = 1'b0;
            for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
            exp_id = '0;
        end
        mem_stop_a = 1'b0; flush_a = 1'b0;
        mem_stop_b = 1'b0; flush_b = 1'b0;
        check("id_reg", (sel == 0) ? CW'(idr_a) : CW'(idr_b), exp_id);
    endtask

    task automatic apply_stimulus(input int sel, input int nbundles);
        int steps;
        bit ms, fl;
        for (int k = 0; k < nbundles; k++) begin
            m_sw = ($urandom() % 2) == 1;
            for (int i = 0; i < 4; i++) begin
                m_v[i]     = (i < nl) && (($urandom() % 4) != 0);
                m_me[i]    = ($urandom() % 2) == 1;
                m_wen[i]   = 4'($urandom());
                m_addr[i]  = $urandom() & 32'hFFFF_FFFC;
                m_wdata[i] = $urandom();
                m_res[i]   = RW'({$urandom(), $urandom(), $urandom()});
            end
            load_bundle(sel);
            steps = 0;
            while ((q.size() > 0 || first) && steps < 40) begin
                ms = (steps < 20) && (($urandom() % 4) == 0);
                fl = ($urandom() % 16) == 0;
                step(sel, ms, fl);
                steps++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        flush_a = 1'b0; mem_stop_a = 1'b0; id_a = '0;
        flush_b = 1'b0; mem_stop_b = 1'b0; id_b = '0;
        set_idle();
        drive_lanes(0);
        drive_lanes(1);
        q.delete();
        first  = 1'b0;
        exp_id = '0;

        repeat (2) @(posedge clk);
        #1;
        nl = 2;
        check_output(0, 1'b0, 1'b0);
        check("id_reset_a", CW'(idr_a), '0);
        nl = 4;
        check_output(1, 1'b0, 1'b0);
        check("id_reset_b", CW'(idr_b), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] two-lane directed bundles");
        nl = 2;
        set_idle();
        m_v[0] = 1'b1; m_v[1] = 1'b1;
        m_me[0] = 1'b1; m_addr[0] = 32'h100; m_wen[0] = 4'h0;
        m_res[0] = RW'(70'h11); m_res[1] = RW'(70'h22);
        load_bundle(0);
        step(0, 1'b0, 1'b0);

        set_idle();
        m_v[0] = 1'b1; m_v[1] = 1'b1; m_me[0] = 1'b1; m_me[1] = 1'b1;
        m_addr[0] = 32'h200; m_wen[0] = 4'hF; m_wdata[0] = 32'hCAFE_F00D;
        m_addr[1] = 32'h204; m_wen[1] = 4'h0;
        load_bundle(0);
        step(0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0);

        load_bundle(0);
        step(0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0);

        load_bundle(0);
        step(0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1);

        set_idle();
        m_v[0] = 1'b1; m_v[1] = 1'b1;
        m_res[0] = RW'(70'h2A_AAAA_AAAA); m_res[1] = RW'(70'h15_5555_5555);
        load_bundle(0);
        step(0, 1'b0, 1'b0);
        m_sw = 1'b1; m_v[0] = 1'b1; m_v[1] = 1'b1;
        load_bundle(0);
        step(0, 1'b0, 1'b0);

        $display("[TB] two-lane random bundles");
        apply_stimulus(0, 40);
        set_idle();
        drive_lanes(0);

        $display("[TB] four-lane bundles");
        nl = 4;
        set_idle();
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 1'b1; m_me[i] = 1'b1;
            m_addr[i] = 32'h300 + 32'(i * 4);
            m_wdata[i] = 32'h1000 + 32'(i);
        end
        load_bundle(1);
        req_high = 0;
        for (int s = 0; s < 4; s++) step(1, 1'b0, 1'b0);
        check("req_cycles", CW'(req_high), CW'(3));

        apply_stimulus(1, 40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
